// File: rtl/imem_arb_if.sv
// Bus bundle between the instruction-memory arbiter, the CPU fetch port,
// the program loader and the single-port instruction BRAM.
interface imem_arb_if;
  // CPU fetch port
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  // program loader port
  logic        l_req;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic        l_gnt;
  logic        l_done;
  // status
  logic        running;
  logic        err;
  logic [15:0] load_cnt;
  // BRAM side, word-indexed
  logic        m_en;
  logic        m_we;
  logic [14:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;

  // Arbiter side
  modport slave (
    input  f_req, f_addr, l_req, l_addr, l_wdata, l_done, m_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, running, err, load_cnt,
           m_en, m_we, m_addr, m_wdata
  );

  // Requesters and memory side
  modport master (
    output f_req, f_addr, l_req, l_addr, l_wdata, l_done, m_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, running, err, load_cnt,
           m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/imem_arb.sv
// Arbitrates a single-port instruction BRAM between the program loader
// (priority) and CPU fetch, with an anti-starvation override in RUN.
module imem_arb #(
  parameter int MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  imem_arb_if.slave    bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [15:0]         load_cnt_q, load_cnt_d;
  logic                rvalid_q, rvalid_d;
  logic                f_oor_q, f_oor_d;

  logic                f_oor;
  logic                l_oor;
  logic                force_fetch;
  logic                f_gnt;
  logic                l_gnt;

  // Byte-lane bits carry no meaning for a word-wide memory.
  logic                unused_lane_bits;
  assign unused_lane_bits = ^{bus.f_addr[1:0], bus.l_addr[1:0]};

  assign f_oor = |bus.f_addr[31:17];
  assign l_oor = |bus.l_addr[31:17];

  // Fetch overtakes the loader only after MAX_WAIT consecutive denials.
  assign force_fetch = (state_q == RUN) && bus.f_req && (wait_q == WAIT_MAX);

  always_comb begin
    l_gnt = 1'b0;
    f_gnt = 1'b0;
    if (!rst) begin
      l_gnt = bus.l_req && !force_fetch;
      f_gnt = (state_q == RUN) && bus.f_req && !l_gnt;
    end
  end

  assign bus.f_gnt = f_gnt;
  assign bus.l_gnt = l_gnt;

  always_comb begin
    bus.m_en    = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    if (l_gnt) begin
      bus.m_en    = !l_oor;
      bus.m_we    = !l_oor;
      bus.m_addr  = bus.l_addr[16:2];
      bus.m_wdata = bus.l_wdata;
    end else if (f_gnt) begin
      bus.m_en    = !f_oor;
      bus.m_addr  = bus.f_addr[16:2];
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    err_d      = err_q;
    load_cnt_d = load_cnt_q;
    rvalid_d   = f_gnt;
    f_oor_d    = f_gnt && f_oor;

    if (state_q == BOOT && bus.l_done) begin
      state_d = RUN;
    end

    if (state_q == RUN && bus.f_req && !f_gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
    end

    if ((l_gnt && l_oor) || (f_gnt && f_oor)) begin
      err_d = 1'b1;
    end

    if (l_gnt && !l_oor && load_cnt_q != 16'hFFFF) begin
      load_cnt_d = load_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BOOT;
      wait_q     <= '0;
      err_q      <= 1'b0;
      load_cnt_q <= '0;
      rvalid_q   <= 1'b0;
      f_oor_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      err_q      <= err_d;
      load_cnt_q <= load_cnt_d;
      rvalid_q   <= rvalid_d;
      f_oor_q    <= f_oor_d;
    end
  end

  assign bus.running  = (state_q == RUN);
  assign bus.err      = err_q;
  assign bus.load_cnt = load_cnt_q;
  assign bus.f_rvalid = rvalid_q;
  // Out-of-range fetches and idle cycles read back as all-ones.
  assign bus.f_rdata  = (rvalid_q && !f_oor_q) ? bus.m_rdata : 32'hFFFF_FFFF;

endmodule

// File: tb/tb_imem_arb.sv
// Self-checking bench for imem_arb: BRAM model on the memory side and a
// queue of expected fetch data checked when f_rvalid is due.
module tb_imem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_arb_if bus ();

  imem_arb #(.MAX_WAIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Instruction BRAM model, one-cycle read latency.
  logic [31:0] bram [0:32767];
  logic [31:0] bram_rdata;
  always @(posedge clk) begin
    if (bus.m_en) begin
      if (bus.m_we) bram[bus.m_addr] <= bus.m_wdata;
      else          bram_rdata <= bram[bus.m_addr];
    end
  end
  assign bus.m_rdata = bram_rdata;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] shadow [0:3];
  int          exp_load = 0;
  logic [31:0] exp_d;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.f_req = 1'b1; bus.l_req = 1'b1;
    bus.f_addr = 32'h0; bus.l_addr = 32'h0;
    @(negedge clk);
    vectors++;
    if ({bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_grants: got %b want 0000", {bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we});
    end
    next_cycle();
    vectors++;
    if ({bus.running, bus.err, bus.f_rvalid} !== 3'b000 || bus.load_cnt !== 16'h0
        || bus.f_rdata !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL reset_state: run/err/rv=%b cnt=%h rdata=%h want 000 0000 ffffffff",
               {bus.running, bus.err, bus.f_rvalid}, bus.load_cnt, bus.f_rdata);
    end
    $display("reset: state checked");
    rst = 1'b0; bus.f_req = 1'b0; bus.l_req = 1'b0;
  endtask

  task automatic test_boot_load();
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    for (int i = 0; i < 3; i++) begin
      shadow[i]   = 32'hC0DE_0000 + 32'(i * 17);
      bus.l_req   = 1'b1;
      bus.l_addr  = 32'(i * 4);
      bus.l_wdata = shadow[i];
      @(negedge clk);
      vectors++;
      if ({bus.l_gnt, bus.f_gnt, bus.m_en, bus.m_we} !== 4'b1011 || bus.m_addr !== 15'(i)) begin
        miscompares++;
        $display("FAIL boot_write%0d: lg/fg/en/we=%b addr=%0d want 1011 addr=%0d",
                 i, {bus.l_gnt, bus.f_gnt, bus.m_en, bus.m_we}, bus.m_addr, i);
      end
      $display("boot: write idx %0d data %h", i, shadow[i]);
      exp_load++;
      next_cycle();
    end
    bus.l_req = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.f_gnt !== 1'b0 || bus.load_cnt !== 16'(exp_load) || bus.running !== 1'b0) begin
      miscompares++;
      $display("FAIL boot_after: fgnt=%b cnt=%0d run=%b want 0 %0d 0",
               bus.f_gnt, bus.load_cnt, bus.running, exp_load);
    end
    next_cycle();
    bus.f_req = 1'b0;
  endtask

  task automatic test_transition();
    bus.l_done = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.running !== 1'b0) begin
      miscompares++;
      $display("FAIL trans_before: running=%b want 0", bus.running);
    end
    next_cycle();
    bus.l_done = 1'b0;
    vectors++;
    if (bus.running !== 1'b1) begin
      miscompares++;
      $display("FAIL trans_after: running=%b want 1", bus.running);
    end
    bus.f_req = 1'b1; bus.f_addr = 32'h8;
    @(negedge clk);
    vectors++;
    if ({bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we} !== 4'b1010 || bus.m_addr !== 15'd2) begin
      miscompares++;
      $display("FAIL trans_fetch: fg/lg/en/we=%b addr=%0d want 1010 addr=2",
               {bus.f_gnt, bus.l_gnt, bus.m_en, bus.m_we}, bus.m_addr);
    end
    exp_q.push_back(shadow[2]);
    next_cycle();
    bus.f_req = 1'b0;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      vectors++;
      if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== exp_d) begin
        miscompares++;
        $display("FAIL trans_rdata: rv=%b data=%h want 1 %h", bus.f_rvalid, bus.f_rdata, exp_d);
      end
      $display("fetch: idx 2 data %h", bus.f_rdata);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      bus.f_req  = (i < 4);
      bus.f_addr = 32'((i % 3) * 4);
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        vectors++;
        if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== exp_d) begin
          miscompares++;
          $display("FAIL b2b_rdata%0d: rv=%b data=%h want 1 %h", i, bus.f_rvalid, bus.f_rdata, exp_d);
        end
        $display("fetch: b2b response %0d data %h", i, bus.f_rdata);
      end
      if (i < 4) begin
        vectors++;
        if (bus.f_gnt !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_gnt%0d: f_gnt=%b want 1", i, bus.f_gnt);
        end
        exp_q.push_back(shadow[i % 3]);
      end
      next_cycle();
    end
    @(negedge clk);
    vectors++;
    if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL b2b_idle: rv=%b data=%h want 0 ffffffff", bus.f_rvalid, bus.f_rdata);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    bus.l_req = 1'b1; bus.l_addr = 32'hC; bus.l_wdata = 32'hA5A5_0003;
    bus.f_req = 1'b1; bus.f_addr = 32'h0;
    for (int k = 0; k < 19; k++) begin
      if (k == 18) begin
        bus.l_req = 1'b0; bus.f_req = 1'b0;
      end
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        vectors++;
        if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== exp_d) begin
          miscompares++;
          $display("FAIL starve_rdata%0d: rv=%b data=%h want 1 %h", k, bus.f_rvalid, bus.f_rdata, exp_d);
        end
      end
      if (k < 18) begin
        vectors++;
        if (bus.f_gnt !== (k % 9 == 8) || bus.l_gnt !== (k % 9 != 8)) begin
          miscompares++;
          $display("FAIL starve_gnt%0d: f_gnt=%b l_gnt=%b want %b %b",
                   k, bus.f_gnt, bus.l_gnt, (k % 9 == 8), (k % 9 != 8));
        end
        $display("starve: cycle %0d f_gnt=%b l_gnt=%b", k, bus.f_gnt, bus.l_gnt);
        if (k % 9 == 8) exp_q.push_back(shadow[0]);
        else            exp_load++;
      end
      next_cycle();
    end
    vectors++;
    if (bus.load_cnt !== 16'(exp_load)) begin
      miscompares++;
      $display("FAIL starve_cnt: load_cnt=%0d want %0d", bus.load_cnt, exp_load);
    end
  endtask

  task automatic test_out_of_range();
    bus.f_req = 1'b1; bus.f_addr = 32'h0002_0000;
    @(negedge clk);
    vectors++;
    if (bus.f_gnt !== 1'b1 || bus.m_en !== 1'b0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_fetch: f_gnt=%b m_en=%b err=%b want 1 0 0", bus.f_gnt, bus.m_en, bus.err);
    end
    exp_q.push_back(32'hFFFF_FFFF);
    next_cycle();
    bus.f_req = 1'b0;
    bus.l_req = 1'b1; bus.l_addr = 32'h8000_0000; bus.l_wdata = 32'h1234_5678;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      vectors++;
      if (bus.f_rvalid !== 1'b1 || bus.f_rdata !== exp_d || bus.err !== 1'b1) begin
        miscompares++;
        $display("FAIL oor_resp: rv=%b data=%h err=%b want 1 %h 1", bus.f_rvalid, bus.f_rdata, bus.err, exp_d);
      end
      $display("fetch: out-of-range data %h", bus.f_rdata);
    end
    vectors++;
    if (bus.l_gnt !== 1'b1 || bus.m_en !== 1'b0 || bus.m_we !== 1'b0) begin
      miscompares++;
      $display("FAIL oor_write: l_gnt=%b m_en=%b m_we=%b want 1 0 0", bus.l_gnt, bus.m_en, bus.m_we);
    end
    next_cycle();
    bus.l_req = 1'b0;
    next_cycle();
    vectors++;
    if (bus.err !== 1'b1 || bus.load_cnt !== 16'(exp_load)) begin
      miscompares++;
      $display("FAIL oor_sticky: err=%b cnt=%0d want 1 %0d", bus.err, bus.load_cnt, exp_load);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bus.f_req = 1'b1; bus.f_addr = 32'h4;
    @(negedge clk);
    vectors++;
    if (bus.f_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_gnt: f_gnt=%b want 1", bus.f_gnt);
    end
    next_cycle();
    rst = 1'b1; bus.f_req = 1'b0;
    exp_q.delete();
    next_cycle();
    vectors++;
    if (bus.f_rvalid !== 1'b0 || bus.f_rdata !== 32'hFFFF_FFFF || bus.running !== 1'b0
        || bus.load_cnt !== 16'h0 || bus.err !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_state: rv=%b data=%h run=%b cnt=%0d err=%b want 0 ffffffff 0 0 0",
               bus.f_rvalid, bus.f_rdata, bus.running, bus.load_cnt, bus.err);
    end
    rst = 1'b0;
    next_cycle();
    vectors++;
    if (bus.f_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_after: rv=%b want 0", bus.f_rvalid);
    end
    $display("reset: mid-fetch reset checked");
  endtask

  task automatic test_saturation();
    bus.l_req = 1'b1; bus.l_addr = 32'h10; bus.l_wdata = 32'h0;
    repeat (65534) @(posedge clk);
    #1;
    vectors++;
    if (bus.load_cnt !== 16'hFFFE) begin
      miscompares++;
      $display("FAIL sat_pre: load_cnt=%h want fffe", bus.load_cnt);
    end
    repeat (6) @(posedge clk);
    #1;
    vectors++;
    if (bus.load_cnt !== 16'hFFFF || bus.f_gnt !== 1'b0) begin
      miscompares++;
      $display("FAIL sat_final: load_cnt=%h f_gnt=%b want ffff 0", bus.load_cnt, bus.f_gnt);
    end
    $display("saturate: 65540 writes load_cnt=%h", bus.load_cnt);
    bus.l_req = 1'b0;
  endtask

  initial begin
    bus.f_req = 1'b0; bus.f_addr = '0;
    bus.l_req = 1'b0; bus.l_addr = '0; bus.l_wdata = '0; bus.l_done = 1'b0;
    #1;
    test_reset();
    test_boot_load();
    test_transition();
    test_back_to_back();
    test_starvation();
    test_out_of_range();
    test_reset_mid_fetch();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
